// File: rtl/axi_txn_arb_pkg.sv
// Shared types and AXI response codes for the single-outstanding AXI transaction arbiter.
package axi_txn_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_txn_arbiter_rr.sv
// Combinational round-robin priority encoder: first request at or after ptr_i wins,
// with an optional fixed top priority for requester 0.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          prio0_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int j;
    j       = 0;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    if (prio0_i && req_i[0]) begin
      gnt_o[0] = 1'b1;
      valid_o  = 1'b1;
    end else begin
      // With requester 0 idle, the circular search also covers the prio0 case.
      for (int i = 0; i < N; i++) begin
        j = (int'(ptr_i) + i) % N;
        if (!valid_o && req_i[j]) begin
          gnt_o[j] = 1'b1;
          idx_o    = IW'(j);
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_txn_arbiter.sv
// Shares one AXI master port among NB_REQ requesters, one single-beat transaction at a time.
// Optional feature macro: AXI_TXN_ARB_PRIO0_EN gives requester 0 fixed top priority.
module axi_txn_arbiter
  import axi_txn_arb_pkg::*;
#(
  parameter int NB_REQ         = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 2
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic [NB_REQ-1:0]                             req_i,
  input  logic [NB_REQ-1:0]                             we_i,
  input  logic [NB_REQ-1:0][AXI_ADDR_WIDTH-1:0]         addr_i,
  input  logic [NB_REQ-1:0][AXI_DATA_WIDTH-1:0]         wdata_i,
  input  logic [NB_REQ-1:0][AXI_DATA_WIDTH/8-1:0]       be_i,
  output logic [NB_REQ-1:0]                             gnt_o,
  output logic [NB_REQ-1:0]                             rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]                     rdata_o,
  output logic                                          err_o,
  output logic                                          aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]                     aw_addr_o,
  output logic [AXI_ID_WIDTH-1:0]                       aw_id_o,
  input  logic                                          aw_ready_i,
  output logic                                          w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]                     w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]                   w_strb_o,
  output logic                                          w_last_o,
  input  logic                                          w_ready_i,
  input  logic                                          b_valid_i,
  input  logic [1:0]                                    b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]                       b_id_i,
  output logic                                          b_ready_o,
  output logic                                          ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]                     ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]                       ar_id_o,
  input  logic                                          ar_ready_i,
  input  logic                                          r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]                     r_data_i,
  input  logic [1:0]                                    r_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]                       r_id_i,
  input  logic                                          r_last_i,
  output logic                                          r_ready_o,
  output logic                                          busy_o
);

  localparam int IW   = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int STRB = AXI_DATA_WIDTH / 8;

  arb_state_e                state_q;
  logic [IW-1:0]             owner_q, rrPtr_q, rrPtr_d, arbIdx;
  logic [NB_REQ-1:0]         arbGnt, rvalid_q;
  logic                      arbValid, grantEn, prio0;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [STRB-1:0]           be_q;
  logic                      awDone_q, wDone_q, err_q;
  logic                      awHs, wHs, bIdErr, rIdErr;

`ifdef AXI_TXN_ARB_PRIO0_EN
  assign prio0 = 1'b1;
`else
  assign prio0 = 1'b0;
`endif

  rr_arbiter #(.N(NB_REQ)) uRrArbiter (
    .req_i   (req_i),
    .ptr_i   (rrPtr_q),
    .prio0_i (prio0),
    .gnt_o   (arbGnt),
    .idx_o   (arbIdx),
    .valid_o (arbValid)
  );

  // IDLE is held for one extra cycle while the response pulse is out, so the
  // earliest next grant lands one cycle after rvalid_o.
  assign grantEn = (state_q == IDLE) && (rvalid_q == '0) && !rst_i;
  assign gnt_o   = grantEn ? arbGnt : '0;
  assign rrPtr_d = (arbIdx == IW'(NB_REQ - 1)) ? '0 : arbIdx + IW'(1);

  assign aw_valid_o = (state_q == WR_REQ) && !awDone_q;
  assign w_valid_o  = (state_q == WR_REQ) && !wDone_q;
  assign b_ready_o  = (state_q == WR_RESP);
  assign ar_valid_o = (state_q == RD_REQ);
  assign r_ready_o  = (state_q == RD_RESP);
  assign busy_o     = (state_q != IDLE);

  assign aw_addr_o = addr_q;
  assign ar_addr_o = addr_q;
  assign aw_id_o   = AXI_ID_WIDTH'(owner_q);
  assign ar_id_o   = AXI_ID_WIDTH'(owner_q);
  assign w_data_o  = wdata_q;
  assign w_strb_o  = be_q;
  assign w_last_o  = 1'b1;

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign awHs   = aw_valid_o && aw_ready_i;
  assign wHs    = w_valid_o && w_ready_i;
  assign bIdErr = (b_id_i != AXI_ID_WIDTH'(owner_q));
  assign rIdErr = (r_id_i != AXI_ID_WIDTH'(owner_q));

  // Transaction FSM, capture registers and the response pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rrPtr_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      awDone_q <= 1'b0;
      wDone_q  <= 1'b0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= '0;
      case (state_q)
        IDLE: begin
          if (grantEn && arbValid) begin
            owner_q  <= arbIdx;
            addr_q   <= addr_i[arbIdx];
            wdata_q  <= wdata_i[arbIdx];
            be_q     <= be_i[arbIdx];
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
            if (!(prio0 && arbIdx == '0)) begin
              rrPtr_q <= rrPtr_d;
            end
            state_q <= we_i[arbIdx] ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          if (awHs) awDone_q <= 1'b1;
          if (wHs)  wDone_q  <= 1'b1;
          if ((awDone_q || awHs) && (wDone_q || wHs)) begin
            state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_valid_i) begin
            rvalid_q <= NB_REQ'(1) << owner_q;
            rdata_q  <= '0;
            err_q    <= (b_resp_i inside {RESP_SLVERR, RESP_DECERR}) || bIdErr;
            state_q  <= IDLE;
          end
        end
        RD_REQ: begin
          if (ar_ready_i) state_q <= RD_RESP;
        end
        RD_RESP: begin
          // A single-beat read missing RLAST is flagged like a bad ID.
          if (r_valid_i) begin
            rvalid_q <= NB_REQ'(1) << owner_q;
            rdata_q  <= r_data_i;
            err_q    <= (r_resp_i inside {RESP_SLVERR, RESP_DECERR}) || rIdErr || !r_last_i;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_txn_arbiter.sv
// Self-checking bench for axi_txn_arbiter: directed scenarios plus randomized transactions
// against a round-robin model (honours AXI_TXN_ARB_PRIO0_EN when defined).
module tb_axi_txn_arbiter;

  localparam int NB  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 2;

  logic                     clk, rst;
  logic [NB-1:0]            req_i, we_i;
  logic [NB-1:0][AW-1:0]    addr_i;
  logic [NB-1:0][DW-1:0]    wdata_i;
  logic [NB-1:0][DW/8-1:0]  be_i;
  logic [NB-1:0]            gnt_o, rvalid_o;
  logic [DW-1:0]            rdata_o;
  logic                     err_o;
  logic                     aw_valid_o, aw_ready_i;
  logic [AW-1:0]            aw_addr_o;
  logic [IDW-1:0]           aw_id_o;
  logic                     w_valid_o, w_last_o, w_ready_i;
  logic [DW-1:0]            w_data_o;
  logic [DW/8-1:0]          w_strb_o;
  logic                     b_valid_i, b_ready_o;
  logic [1:0]               b_resp_i;
  logic [IDW-1:0]           b_id_i;
  logic                     ar_valid_o, ar_ready_i;
  logic [AW-1:0]            ar_addr_o;
  logic [IDW-1:0]           ar_id_o;
  logic                     r_valid_i, r_last_i, r_ready_o;
  logic [DW-1:0]            r_data_i;
  logic [1:0]               r_resp_i;
  logic [IDW-1:0]           r_id_i;
  logic                     busy_o;

  int checks = 0;
  int errors = 0;
  int modelPtr = 0;
  bit inRespCycle = 0;

  axi_txn_arbiter #(
    .NB_REQ(NB), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IDW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .aw_valid_o(aw_valid_o), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o), .aw_ready_i(aw_ready_i),
    .w_valid_o(w_valid_o), .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .w_ready_i(w_ready_i),
    .b_valid_i(b_valid_i), .b_resp_i(b_resp_i), .b_id_i(b_id_i), .b_ready_o(b_ready_o),
    .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o), .ar_ready_i(ar_ready_i),
    .r_valid_i(r_valid_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_id_i(r_id_i),
    .r_last_i(r_last_i), .r_ready_o(r_ready_o),
    .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Winner = requested index with the smallest circular distance from the pointer.
  function automatic int modelPick(input logic [NB-1:0] m);
    int best;
    int bestDist;
    best = -1;
    bestDist = NB + 1;
`ifdef AXI_TXN_ARB_PRIO0_EN
    if (m[0]) return 0;
`endif
    for (int i = 0; i < NB; i++) begin
      if (m[i] && ((i - modelPtr + NB) % NB) < bestDist) begin
        best = i;
        bestDist = (i - modelPtr + NB) % NB;
      end
    end
    return best;
  endfunction

  function automatic void modelAdvance(input int win);
`ifdef AXI_TXN_ARB_PRIO0_EN
    if (win == 0) return;
`endif
    modelPtr = (win + 1) % NB;
  endfunction

  task automatic randomPayload();
    for (int i = 0; i < NB; i++) begin
      addr_i[i]  = $urandom;
      wdata_i[i] = $urandom;
      be_i[i]    = 4'($urandom_range(1, 15));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, {gnt_o, rvalid_o, rdata_o, err_o, aw_valid_o, w_valid_o,
                      b_ready_o, ar_valid_o, r_ready_o, busy_o}, 64'd0);
  endtask

  // One complete transaction; called at a negedge, returns at the rvalid negedge.
  task automatic applyStimulus(input logic [NB-1:0] mask, input logic [NB-1:0] weMask,
                               input int awDly, input int wDly, input int arDly, input int rspDly,
                               input logic [1:0] resp, input logic [DW-1:0] rdat,
                               input bit badId, input bit resetInResp);
    int win;
    int cyc;
    int awCnt;
    int wCnt;
    bit awSeen;
    bit wSeen;
    logic [AW-1:0]   eAddr;
    logic [DW-1:0]   eData;
    logic [DW/8-1:0] eBe;
    logic            eWe;
    logic [IDW-1:0]  rspId;

    win = modelPick(mask);
    req_i = mask;
    we_i  = weMask;
    #1;
    if (inRespCycle) checkOutput("gntInRespCycle", gnt_o, 0);
    inRespCycle = 0;
    cyc = 0;
    while (gnt_o === '0 && cyc < 10) begin
      @(negedge clk); #1; cyc++;
    end
    checkOutput("grant", gnt_o, 64'(1) << win);
    checkOutput("busyAtGrant", busy_o, 0);
    eAddr = addr_i[win];
    eData = wdata_i[win];
    eBe   = be_i[win];
    eWe   = weMask[win];
    modelAdvance(win);
    rspId = badId ? IDW'(win + 1) : IDW'(win);

    @(negedge clk);
    req_i = mask & ~(NB'(1) << win);
    randomPayload();
    we_i = NB'($urandom);
    #1;
    checkOutput("busyAfterGrant", busy_o, 1);

    if (eWe) begin
      awSeen = 0; wSeen = 0; awCnt = awDly; wCnt = wDly; cyc = 0;
      while (!(awSeen && wSeen) && cyc < 40) begin
        checkOutput("noGntWhileBusy", gnt_o, 0);
        checkOutput("bReadyEarly", b_ready_o, 0);
        checkOutput("awValid", aw_valid_o, !awSeen);
        checkOutput("wValid", w_valid_o, !wSeen);
        aw_ready_i = !awSeen && awCnt == 0;
        w_ready_i  = !wSeen && wCnt == 0;
        if (aw_ready_i) begin
          checkOutput("awAddr", aw_addr_o, eAddr);
          checkOutput("awId", aw_id_o, win);
        end
        if (w_ready_i) begin
          checkOutput("wData", w_data_o, eData);
          checkOutput("wStrb", w_strb_o, eBe);
          checkOutput("wLast", w_last_o, 1);
        end
        @(posedge clk);
        if (aw_ready_i) awSeen = 1; else if (!awSeen) awCnt--;
        if (w_ready_i) wSeen = 1; else if (!wSeen) wCnt--;
        @(negedge clk);
        aw_ready_i = 0;
        w_ready_i  = 0;
        #1;
        cyc++;
      end
      checkOutput("wrHandshakesDone", awSeen && wSeen, 1);
      repeat (rspDly) begin
        checkOutput("bReadyWait", b_ready_o, 1);
        @(negedge clk); #1;
      end
      b_valid_i = 1; b_resp_i = resp; b_id_i = rspId;
      checkOutput("bReady", b_ready_o, 1);
      @(negedge clk);
      b_valid_i = 0; b_resp_i = 2'($urandom);
      #1;
      checkOutput("rvalidWr", rvalid_o, 64'(1) << win);
      checkOutput("rdataWr", rdata_o, 0);
      checkOutput("errWr", err_o, resp[1] | badId);
    end else begin
      cyc = 0;
      while (cyc < arDly) begin
        checkOutput("arValidHold", ar_valid_o, 1);
        checkOutput("noGntWhileBusy", gnt_o, 0);
        @(negedge clk); #1; cyc++;
      end
      ar_ready_i = 1;
      checkOutput("arValid", ar_valid_o, 1);
      checkOutput("arAddr", ar_addr_o, eAddr);
      checkOutput("arId", ar_id_o, win);
      @(negedge clk);
      ar_ready_i = 0;
      #1;
      checkOutput("arDropped", ar_valid_o, 0);
      if (resetInResp) begin
        rst = 1;
        #1;
        checkResetOutputs("resetAsync");
        @(negedge clk); #1;
        checkResetOutputs("resetNextCycle");
        rst = 0;
        req_i = '0;
        modelPtr = 0;
        return;
      end
      repeat (rspDly) begin
        checkOutput("rReadyWait", r_ready_o, 1);
        @(negedge clk); #1;
      end
      r_valid_i = 1; r_data_i = rdat; r_resp_i = resp; r_last_i = 1; r_id_i = rspId;
      checkOutput("rReady", r_ready_o, 1);
      @(negedge clk);
      r_valid_i = 0; r_data_i = $urandom; r_resp_i = 2'($urandom);
      #1;
      checkOutput("rvalidRd", rvalid_o, 64'(1) << win);
      checkOutput("rdataRd", rdata_o, rdat);
      checkOutput("errRd", err_o, resp[1] | badId);
    end
    checkOutput("busyAtRvalid", busy_o, 0);
    inRespCycle = 1;
  endtask

  initial begin
    rst = 1;
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0; b_id_i = 0;
    ar_ready_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0; r_id_i = 0; r_last_i = 1;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("resetState");
    rst = 0;
    @(negedge clk);

    $display("[TB] single write");
    randomPayload();
    addr_i[1] = 32'h0010_0040; wdata_i[1] = 32'hDEAD_BEEF; be_i[1] = 4'hF;
    applyStimulus(4'b0010, 4'b0010, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0);

    $display("[TB] read with slave error");
    randomPayload();
    addr_i[2] = 32'h1A10_0000;
    applyStimulus(4'b0100, 4'b0000, 0, 0, 0, 1, 2'b10, 32'h1234_5678, 0, 0);

    $display("[TB] reset during read response");
    randomPayload();
    applyStimulus(4'b1000, 4'b0000, 0, 0, 1, 0, 2'b00, 32'h0, 0, 1);

    $display("[TB] round robin with all requesters");
    for (int t = 0; t < 5; t++) begin
      randomPayload();
      applyStimulus(4'b1111, NB'($urandom), 0, 0, 0, 0, 2'b00, $urandom, 0, 0);
    end

    $display("[TB] split AW/W handshakes");
    randomPayload();
    applyStimulus(4'b1000, 4'b1000, 3, 0, 0, 0, 2'b00, 32'h0, 0, 0);

    $display("[TB] mismatched response ID");
    randomPayload();
    applyStimulus(4'b0001, 4'b0000, 0, 0, 2, 0, 2'b00, 32'hCAFE_F00D, 1, 0);

    $display("[TB] requester 0 idle, others held");
    for (int t = 0; t < 4; t++) begin
      randomPayload();
      applyStimulus(4'b1110, NB'($urandom), 1, 0, 0, 0, 2'b00, $urandom, 0, 0);
    end

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      logic [NB-1:0] m;
      m = NB'($urandom_range(1, (1 << NB) - 1));
      randomPayload();
      applyStimulus(m, NB'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), $urandom,
                    ($urandom_range(0, 7) == 0), 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
